// File: rtl/mvm_seq_pkg.sv
// mvm_seq_pkg
// Shared types and constants for the matrix-vector multiply sequencer:
// FSM state encoding, default matrix dimension / word width, and the
// width helper for the per-phase word counter.
package mvm_seq_pkg;

    localparam int MVM_K_DEF = 32;
    localparam int MVM_B_DEF = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LDM_PULSE = 3'd1,
        LDM_DATA  = 3'd2,
        LDV_PULSE = 3'd3,
        LDV_DATA  = 3'd4,
        START     = 3'd5,
        WAIT_DONE = 3'd6
    } state_t;

    // Counter must be able to hold K*K (largest phase length).
    function automatic int word_cnt_width(input int k);
        return $clog2(k * k + 1);
    endfunction

endpackage

// File: rtl/mvm_seq_lat_counter.sv
// mvm_seq_lat_counter
// 32-bit saturating cycle counter used to measure compute latency.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - zero the count (takes priority over inc)
//   inc         - advance the count by one, saturating at all-ones
//   count_inc   - saturating count+1, i.e. the value including the current cycle
module mvm_seq_lat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [31:0] count_inc
);

    logic [31:0] count;

    assign count_inc = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl
// Sequencing controller for one MVM datapath. Accepts a run command,
// forwards K*K matrix words (unless reusing the stored matrix) and K vector
// words back-to-back, pulses start, then waits for done.
// Optional feature macro: MVM_SEQ_PERF_EN enables the per-run latency
// counter; without it lat_cycles is tied to 0.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   cmd_valid/cmd_ready        - run request handshake (ready only in IDLE)
//   cmd_vec_only               - reuse stored matrix, load vector only
//   in_valid/in_ready/in_data  - upstream word stream (ready only in data states)
//   mvm_loadm/loadv/start      - one-cycle pulses to the datapath
//   mvm_data                   - word forwarded to the datapath
//   mvm_done                   - datapath completion
//   run_done                   - one-cycle pulse on run completion
//   err                        - sticky {nomat, underrun}
//   lat_cycles                 - latency of last completed run
//
// state     | meaning
// IDLE      | waiting for a command
// LDM_PULSE | loadm pulse
// LDM_DATA  | streaming K*K matrix words
// LDV_PULSE | loadv pulse
// LDV_DATA  | streaming K vector words
// START     | start pulse
// WAIT_DONE | waiting for datapath done
module mvm_seq_ctrl
    import mvm_seq_pkg::*;
#(
    parameter int K = MVM_K_DEF,
    parameter int B = MVM_B_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_vec_only,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [B-1:0] in_data,
    output logic         mvm_loadm,
    output logic         mvm_loadv,
    output logic         mvm_start,
    output logic [B-1:0] mvm_data,
    input  logic         mvm_done,
    output logic         run_done,
    output logic [1:0]   err,
    output logic [31:0]  lat_cycles
);

    localparam int CNT_W = word_cnt_width(K);
    localparam logic [CNT_W-1:0] MAT_LAST = CNT_W'(K * K - 1);
    localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(K - 1);

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic             mat_valid;
    logic             data_state;

    assign data_state = (state == LDM_DATA) || (state == LDV_DATA);
    assign cmd_ready  = (state == IDLE);
    assign in_ready   = data_state;
    assign mvm_loadm  = (state == LDM_PULSE);
    assign mvm_loadv  = (state == LDV_PULSE);
    assign mvm_start  = (state == START);
    // Datapath cannot stall: a missing word is forwarded as zero.
    assign mvm_data   = (data_state && in_valid) ? in_data : '0;
    assign run_done   = (state == WAIT_DONE) && mvm_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            mat_valid <= 1'b0;
            err       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        err <= 2'b00;
                        if (!cmd_vec_only) begin
                            state <= LDM_PULSE;
                        end else if (mat_valid) begin
                            state <= LDV_PULSE;
                        end else begin
                            err <= 2'b10;
                        end
                    end
                end
                LDM_PULSE: state <= LDM_DATA;
                LDM_DATA: begin
                    if (!in_valid) begin
                        // A partially loaded matrix is unusable.
                        err[0]    <= 1'b1;
                        mat_valid <= 1'b0;
                        word_cnt  <= '0;
                        state     <= IDLE;
                    end else if (word_cnt == MAT_LAST) begin
                        word_cnt  <= '0;
                        mat_valid <= 1'b1;
                        state     <= LDV_PULSE;
                    end else begin
                        word_cnt <= word_cnt + CNT_W'(1);
                    end
                end
                LDV_PULSE: state <= LDV_DATA;
                LDV_DATA: begin
                    if (!in_valid) begin
                        err[0]   <= 1'b1;
                        word_cnt <= '0;
                        state    <= IDLE;
                    end else if (word_cnt == VEC_LAST) begin
                        word_cnt <= '0;
                        state    <= START;
                    end else begin
                        word_cnt <= word_cnt + CNT_W'(1);
                    end
                end
                START: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (mvm_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MVM_SEQ_PERF_EN
    logic [31:0] lat_next;

    // Counter is zeroed in START so it reads 0 in the first WAIT_DONE cycle.
    mvm_seq_lat_counter u_lat_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == START),
        .inc       (state == WAIT_DONE),
        .count_inc (lat_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cycles <= '0;
        end else if (run_done) begin
            lat_cycles <= lat_next;
        end
    end
`else
    assign lat_cycles = '0;
`endif

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb_mvm_seq_ctrl
// Directed bench for mvm_seq_ctrl with K=4, B=32. A small behavioural MVM
// model raises done a programmable number of cycles after start. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle numbers are relative to the command accept cycle.
module tb_mvm_seq_ctrl;

    localparam int K = 4;
    localparam int B = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_vec_only = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [B-1:0] in_data = '0;
    logic         mvm_loadm;
    logic         mvm_loadv;
    logic         mvm_start;
    logic [B-1:0] mvm_data;
    logic         mvm_done;
    logic         run_done;
    logic [1:0]   err;
    logic [31:0]  lat_cycles;

    mvm_seq_ctrl #(.K(K), .B(B)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_vec_only (cmd_vec_only),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mvm_loadm    (mvm_loadm),
        .mvm_loadv    (mvm_loadv),
        .mvm_start    (mvm_start),
        .mvm_data     (mvm_data),
        .mvm_done     (mvm_done),
        .run_done     (run_done),
        .err          (err),
        .lat_cycles   (lat_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural MVM: done for done_len cycles starting done_delay after start
    logic man_done = 1'b0;
    logic model_on = 1'b1;
    int   done_delay = 5;
    int   done_len = 1;
    int   done_at = 1000000000;
    assign mvm_done = man_done | (model_on && (cyc >= done_at) && (cyc < done_at + done_len));

    // monitor (per-run stats reset on command accept)
    int t0 = 0, rel;
    int n_loadm = 0, n_loadv = 0, n_start = 0, n_rd = 0, tot_rd = 0;
    int t_loadm = -1, t_loadv = -1, t_start = -1, t_rd = -1, t_ready_back = -1;
    int n_not_ready = 0, n_data_bad = 0;
    logic [31:0] words[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid && cmd_ready) begin
                t0 = cyc;
                n_loadm = 0; n_loadv = 0; n_start = 0; n_rd = 0;
                n_not_ready = 0; n_data_bad = 0;
                t_loadm = -1; t_loadv = -1; t_start = -1; t_rd = -1; t_ready_back = -1;
                words.delete();
            end
            rel = cyc - t0;
            if (mvm_loadm) begin n_loadm++; t_loadm = rel; end
            if (mvm_loadv) begin n_loadv++; t_loadv = rel; end
            if (mvm_start) begin n_start++; t_start = rel; done_at = cyc + done_delay; end
            if (run_done)  begin n_rd++; tot_rd++; t_rd = rel; end
            if (!cmd_ready) n_not_ready++;
            else if (rel > 0 && t_ready_back < 0) t_ready_back = rel;
            if (in_ready) words.push_back(mvm_data);
            if (mvm_data !== ((in_ready && in_valid) ? in_data : 32'h0)) n_data_bad++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lat_exp(input int v);
`ifdef MVM_SEQ_PERF_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command; ncyc cycles including the accept cycle. drop = word index
    // (0..15 matrix, 16..19 vector) whose in_valid is withheld, -1 for none.
    task automatic do_run(input bit vec_only, input int drop, input int ncyc,
                          input logic [31:0] vec_word);
        int  g;
        bit  win;
        cmd_valid    = 1'b1;
        cmd_vec_only = vec_only;
        in_valid     = 1'b0;
        in_data      = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0;
        for (int r = 1; r < ncyc; r++) begin
            win = 1'b0;
            g   = 0;
            if (!vec_only && r >= 2 && r <= 17) begin win = 1'b1; g = r - 2; end
            else if (!vec_only && r >= 19 && r <= 22) begin win = 1'b1; g = r - 3; end
            else if (vec_only && r >= 2 && r <= 5) begin win = 1'b1; g = 16 + r - 2; end
            in_valid = win && (g != drop);
            in_data  = !win ? 32'hDEAD_BEEF : (g < 16) ? 32'(g) : vec_word;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic check_idle(input string tag, input logic [31:0] lat);
        @(negedge clk);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_pulses"},    {29'd0, mvm_loadm, mvm_loadv, mvm_start}, 32'd0);
        check({tag, "_run_done"},  32'(run_done),  32'd0);
        check({tag, "_mvm_data"},  mvm_data,       32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_lat"},       lat_cycles,     lat);
    endtask

    int rd_base;

    initial begin
        // reset state
        reset = 1'b1;
        repeat (3) tick();
        check_idle("reset", 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // vector-only with no stored matrix
        do_run(1'b1, -1, 6, 32'hA5);
        check("nomat_err", 32'(err), 32'd2);
        check("nomat_pulses", 32'(n_loadm + n_loadv + n_start), 32'd0);
        check("nomat_ready", 32'(n_not_ready), 32'd0);
        tick();

        // full run, done 5 cycles after start
        done_delay = 5; done_len = 1;
        do_run(1'b0, -1, 31, 32'd1);
        check("full_t_loadm", 32'(t_loadm), 32'd1);
        check("full_t_loadv", 32'(t_loadv), 32'd18);
        check("full_t_start", 32'(t_start), 32'd23);
        check("full_t_rd", 32'(t_rd), 32'd28);
        check("full_n_rd", 32'(n_rd), 32'd1);
        check("full_ready_back", 32'(t_ready_back), 32'd29);
        check("full_nwords", 32'(words.size()), 32'd20);
        check("full_w7", (words.size() > 7) ? words[7] : 32'hFFFF_FFFF, 32'd7);
        check("full_w15", (words.size() > 15) ? words[15] : 32'hFFFF_FFFF, 32'd15);
        check("full_w19", (words.size() > 19) ? words[19] : 32'hFFFF_FFFF, 32'd1);
        check("full_data", 32'(n_data_bad), 32'd0);
        check("full_err", 32'(err), 32'd0);
        check("full_lat", lat_cycles, lat_exp(5));

        // vector-only reusing the stored matrix, done 3 cycles after start
        done_delay = 3;
        do_run(1'b1, -1, 12, 32'hA5);
        check("vec_n_loadm", 32'(n_loadm), 32'd0);
        check("vec_t_loadv", 32'(t_loadv), 32'd1);
        check("vec_t_start", 32'(t_start), 32'd6);
        check("vec_t_rd", 32'(t_rd), 32'd9);
        check("vec_nwords", 32'(words.size()), 32'd4);
        check("vec_w3", (words.size() > 3) ? words[3] : 32'hFFFF_FFFF, 32'hA5);
        check("vec_data", 32'(n_data_bad), 32'd0);
        check("vec_lat", lat_cycles, lat_exp(3));

        // spurious done in IDLE
        rd_base = tot_rd;
        man_done = 1'b1;
        tick(); tick();
        man_done = 1'b0;
        tick();
        @(negedge clk);
        check("spur_rd", 32'(tot_rd - rd_base), 32'd0);
        check("spur_ready", 32'(cmd_ready), 32'd1);
        check("spur_lat", lat_cycles, lat_exp(3));
        tick();

        // done held two cycles: exactly one run_done
        done_delay = 5; done_len = 2;
        do_run(1'b0, -1, 32, 32'd1);
        check("hold_n_rd", 32'(n_rd), 32'd1);
        check("hold_t_rd", 32'(t_rd), 32'd28);
        check("hold_lat", lat_cycles, lat_exp(5));
        done_len = 1;

        // underrun at matrix word 7
        do_run(1'b0, 7, 14, 32'd1);
        check("under_err", 32'(err), 32'd1);
        check("under_start", 32'(n_start + n_loadv), 32'd0);
        check("under_nwords", 32'(words.size()), 32'd8);
        check("under_w7", (words.size() > 7) ? words[7] : 32'hFFFF_FFFF, 32'd0);
        check("under_ready_back", 32'(t_ready_back), 32'd10);
        check("under_data", 32'(n_data_bad), 32'd0);
        do_run(1'b1, -1, 6, 32'hA5);
        check("under_nomat_err", 32'(err), 32'd2);
        check("under_nomat_loadv", 32'(n_loadv), 32'd0);

        // reset while in WAIT_DONE, then a late done
        model_on = 1'b0;
        do_run(1'b0, -1, 27, 32'd1);
        check("rstw_in_wait", 32'(cmd_ready), 32'd0);
        rd_base = tot_rd;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        man_done = 1'b1;
        check_idle("rstw", 32'd0);
        tick(); tick();
        man_done = 1'b0;
        tick();
        check("rstw_rd", 32'(tot_rd - rd_base), 32'd0);
        model_on = 1'b1;
        do_run(1'b1, -1, 6, 32'hA5);
        check("rstw_nomat_err", 32'(err), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
